iir_mac_sched: RTL and testbench

Time-multiplexed scheduler for the direct-form-I IIR filter. It accepts one signed sample per handshake and sequences the feed-forward (zero) taps, then the feedback (pole) taps, through a single shared multiply-accumulate. It scales and saturates the result, updates the x/y history and emits one output sample. It sits between the ADC sample-format conversion stage and the DAC-side output, replacing the parallel zero/pole multiplier banks. Coefficients are loaded at run time through a simple write port.

---
 rtl/iir_pkg.sv | 45 ++++
 rtl/iir_mac_sched_if.sv | 30 +++
 rtl/iir_mac.sv | 31 +++
 rtl/iir_mac_sched.sv | 133 +++++++++++++
 tb/tb_iir_mac_sched.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared widths, state enum, address map and saturation helper for the IIR MAC scheduler
// Purpose: common definitions imported by the interface, the MAC and the scheduler.
// Ports: none (package).
package iir_pkg;

  localparam int DW     = 12;           // sample width (signed)
  localparam int CW     = 13;           // coefficient width (signed)
  localparam int NZ     = 4;            // feed-forward taps b[0..NZ-1]
  localparam int NP     = 3;            // feedback taps a[1..NP]
  localparam int SHIFT  = 10;           // output scaling
  localparam int AW     = DW + CW + 4;  // accumulator width
  localparam int ADDR_W = 3;            // coefficient address width

  localparam int B_BASE = 0;
  localparam int A_BASE = NZ;

  // Tap counter wide enough for the longer of the two tap loops.
  localparam int KW = $clog2((NZ > NP) ? NZ : NP);

  // b[0] at unity gain makes the reset filter the identity.
  localparam logic signed [CW-1:0] B0_UNITY = CW'(2 ** SHIFT);

  localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE,
    MAC_Z,
    MAC_P,
    DONE
  } state_t;

  // Arithmetic shift (floor) followed by clamping to the output sample range.
  function automatic logic signed [DW-1:0] sat_shift(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] r;
    r = acc >>> SHIFT;
    if (r > SAT_MAX)
      return SAT_MAX[DW-1:0];
    else if (r < SAT_MIN)
      return SAT_MIN[DW-1:0];
    else
      return r[DW-1:0];
  endfunction

endpackage

// File: rtl/iir_mac_sched_if.sv
// rtl/iir_mac_sched_if.sv - sample, coefficient and status signals of the IIR MAC scheduler
// Purpose: bundles the sample handshake, coefficient write port and status outputs.
// Signals: in_valid/in_data/in_ready (sample in), cfg_we/cfg_addr/cfg_data/cfg_err
//          (coefficient writes), out_valid/out_data (filtered sample), overrun (sticky drop flag).
// Modports: master drives samples and writes; slave is the scheduler.
interface iir_mac_sched_if;
  import iir_pkg::*;

  logic                     in_valid;
  logic signed [DW-1:0]     in_data;
  logic                     in_ready;
  logic                     cfg_we;
  logic        [ADDR_W-1:0] cfg_addr;
  logic signed [CW-1:0]     cfg_data;
  logic                     cfg_err;
  logic                     out_valid;
  logic signed [DW-1:0]     out_data;
  logic                     overrun;

  modport master (
    output in_valid, in_data, cfg_we, cfg_addr, cfg_data,
    input  in_ready, cfg_err, out_valid, out_data, overrun
  );

  modport slave (
    input  in_valid, in_data, cfg_we, cfg_addr, cfg_data,
    output in_ready, cfg_err, out_valid, out_data, overrun
  );

endinterface

// File: rtl/iir_mac.sv
// rtl/iir_mac.sv - single-cycle signed multiply-accumulate register
// Purpose: acc <= 0 on clr, acc <= acc +/- a*b on en (sub selects subtraction).
// Ports: clk, rst (sync active-high), clr, en, sub, a (DW signed), b (CW signed), acc (AW signed).
module iir_mac
  import iir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 sub,
  input  logic signed [DW-1:0] a,
  input  logic signed [CW-1:0] b,
  output logic signed [AW-1:0] acc
);

  logic signed [DW+CW-1:0] prod;
  logic signed [AW-1:0]    prod_ext;

  // Operands are widened to the full product width so the multiply is exact.
  assign prod     = $signed({{CW{a[DW-1]}}, a}) * $signed({{DW{b[CW-1]}}, b});
  assign prod_ext = {{(AW-DW-CW){prod[DW+CW-1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst || clr)
      acc <= '0;
    else if (en)
      acc <= sub ? (acc - prod_ext) : (acc + prod_ext);
  end

endmodule

// File: rtl/iir_mac_sched.sv
// rtl/iir_mac_sched.sv - time-multiplexed direct-form-I IIR scheduler around one shared MAC
// Purpose: accepts a sample, runs NZ zero taps then NP pole taps through iir_mac,
//          scales/saturates the sum, updates x/y history and emits one output sample.
// Ports: sys_clk, sys_rst (sync active-high), bus (iir_mac_sched_if.slave).
module iir_mac_sched
  import iir_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst,
  iir_mac_sched_if.slave   bus
);

  state_t                state;
  logic [KW-1:0]         tap;
  logic signed [CW-1:0]  coef_b [NZ];   // b[0..NZ-1]
  logic signed [CW-1:0]  coef_a [NP];   // coef_a[i] holds a[i+1]
  logic signed [DW-1:0]  x_hist [NZ];   // x_hist[0] is the newest input
  logic signed [DW-1:0]  y_hist [NP];   // y_hist[i] holds y[i+1]

  logic                  accept;
  logic                  mac_en;
  logic                  mac_sub;
  logic signed [DW-1:0]  mac_a;
  logic signed [CW-1:0]  mac_b;
  logic signed [AW-1:0]  acc;
  logic signed [DW-1:0]  result;

  assign bus.in_ready = (state == IDLE);
  assign accept       = bus.in_valid && (state == IDLE);
  assign result       = sat_shift(acc);

  always_comb begin
    mac_en  = 1'b0;
    mac_sub = 1'b0;
    mac_a   = x_hist[tap];
    mac_b   = coef_b[tap];
    if (state == MAC_Z) begin
      mac_en = 1'b1;
    end else if (state == MAC_P) begin
      mac_en  = 1'b1;
      mac_sub = 1'b1;
      mac_a   = y_hist[tap];
      mac_b   = coef_a[tap];
    end
  end

  // The accumulator is cleared in the accept cycle so the first zero tap
  // lands on a clean sum one cycle later.
  iir_mac u_mac (
    .clk (sys_clk),
    .rst (sys_rst),
    .clr (accept),
    .en  (mac_en),
    .sub (mac_sub),
    .a   (mac_a),
    .b   (mac_b),
    .acc (acc)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= IDLE;
      tap           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.cfg_err   <= 1'b0;
      bus.overrun   <= 1'b0;
      for (int i = 0; i < NZ; i++) begin
        x_hist[i] <= '0;
        coef_b[i] <= '0;
      end
      for (int i = 0; i < NP; i++) begin
        y_hist[i] <= '0;
        coef_a[i] <= '0;
      end
      coef_b[0] <= B0_UNITY;
    end else begin
      bus.out_valid <= 1'b0;
      bus.cfg_err   <= bus.cfg_we && (state != IDLE);
      if (bus.in_valid && (state != IDLE))
        bus.overrun <= 1'b1;

      // Writes land before MAC_Z reads any tap, so a write in the accept
      // cycle already applies to that sample. Unmapped addresses are ignored.
      if (bus.cfg_we && (state == IDLE)) begin
        for (int i = 0; i < NZ; i++)
          if (bus.cfg_addr == ADDR_W'(B_BASE + i))
            coef_b[i] <= bus.cfg_data;
        for (int i = 0; i < NP; i++)
          if (bus.cfg_addr == ADDR_W'(A_BASE + i))
            coef_a[i] <= bus.cfg_data;
      end

      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int i = NZ - 1; i > 0; i--)
              x_hist[i] <= x_hist[i-1];
            x_hist[0] <= bus.in_data;
            tap       <= '0;
            state     <= MAC_Z;
          end
        end
        MAC_Z: begin
          if (tap == KW'(NZ - 1)) begin
            tap   <= '0;
            state <= MAC_P;
          end else begin
            tap <= tap + KW'(1);
          end
        end
        MAC_P: begin
          if (tap == KW'(NP - 1)) begin
            tap   <= '0;
            state <= DONE;
          end else begin
            tap <= tap + KW'(1);
          end
        end
        DONE: begin
          bus.out_data  <= result;
          bus.out_valid <= 1'b1;
          for (int i = NP - 1; i > 0; i--)
            y_hist[i] <= y_hist[i-1];
          y_hist[0] <= result;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_mac_sched.sv
// tb/tb_iir_mac_sched.sv - self-checking bench for iir_mac_sched
module tb_iir_mac_sched;
  import iir_pkg::*;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  iir_mac_sched_if bus ();

  iir_mac_sched dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: direct-form-I difference equation on plain integers.
  longint mb [NZ];
  longint ma [NP];
  longint mx [NZ];
  longint my [NP];

  typedef struct {
    bit rst;
    bit cfg;
    int b0;
    int b1;
    int a1;
    int din;
    int exp;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NZ; i++) begin mb[i] = 0; mx[i] = 0; end
    for (int i = 0; i < NP; i++) begin ma[i] = 0; my[i] = 0; end
    mb[0] = 1 << SHIFT;
  endtask

  task automatic model_cfg(input int addr, input int data);
    if (addr < NZ) mb[addr] = data;
    else if (addr < NZ + NP) ma[addr-NZ] = data;
  endtask

  task automatic model_step(input int din, output int y);
    longint s;
    for (int i = NZ - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = din;
    s = 0;
    for (int i = 0; i < NZ; i++) s += mb[i] * mx[i];
    for (int i = 0; i < NP; i++) s -= ma[i] * my[i];
    s = s >>> SHIFT;
    if (s > 2047) s = 2047;
    if (s < -2048) s = -2048;
    for (int i = NP - 1; i > 0; i--) my[i] = my[i-1];
    my[0] = s;
    y = int'(s);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst      = 1'b1;
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input int addr, input int data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = ADDR_W'(addr);
    bus.cfg_data = CW'(data);
    @(negedge sys_clk);
    bus.cfg_we = 1'b0;
    model_cfg(addr, data);
  endtask

  // Offers a sample (optionally with a same-cycle write) and returns at the
  // falling edge of the cycle after the accept.
  task automatic do_accept(input int din, input bit we, input int addr, input int data);
    int n = 0;
    while (!bus.in_ready && n < 30) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 30) chk("ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(din);
    bus.cfg_we   = we;
    bus.cfg_addr = ADDR_W'(addr);
    bus.cfg_data = CW'(data);
    @(negedge sys_clk);
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
  endtask

  // n counts cycles after the accept cycle; starts at the caller's position.
  task automatic wait_out(input int n0, output int n, output int got);
    n = n0;
    while (!bus.out_valid && n < 30) begin
      @(negedge sys_clk);
      n++;
    end
    got = int'(bus.out_data);
  endtask

  initial begin
    vec_t tv [10];
    int   n, got, exp, cnt;
    int   acc_cyc [$];
    logic signed [CW-1:0] rc;
    logic signed [DW-1:0] rd;

    tv[0] = '{1, 0, 0, 0, 0, 100, 100};
    tv[1] = '{0, 0, 0, 0, 0, -37, -37};
    tv[2] = '{1, 1, 512, 512, 0, 1000, 500};
    tv[3] = '{0, 0, 0, 0, 0, 200, 600};
    tv[4] = '{1, 1, 1024, 0, -512, 1000, 1000};
    tv[5] = '{0, 0, 0, 0, 0, 0, 500};
    tv[6] = '{0, 0, 0, 0, 0, 0, 250};
    tv[7] = '{0, 0, 0, 0, 0, 0, 125};
    tv[8] = '{1, 1, 4095, 0, 0, 2047, 2047};
    tv[9] = '{0, 0, 0, 0, 0, -2048, -2048};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;

    do_reset();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    chk("rst_overrun", bus.overrun, 0);

    for (int i = 0; i < 10; i++) begin
      if (tv[i].rst) do_reset();
      if (tv[i].cfg) begin
        cfg_write(0, tv[i].b0);
        cfg_write(1, tv[i].b1);
        cfg_write(A_BASE, tv[i].a1);
      end
      do_accept(tv[i].din, 1'b0, 0, 0);
      wait_out(1, n, got);
      chk($sformatf("vec%0d_latency", i), n, 9);
      chk($sformatf("vec%0d_data", i), got, tv[i].exp);
    end

    // Write while busy: rejected, pulses cfg_err once, coefficient untouched.
    do_reset();
    do_accept(5, 1'b0, 0, 0);
    @(negedge sys_clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = '0;
    bus.cfg_data = CW'(7);
    @(negedge sys_clk);
    bus.cfg_we = 1'b0;
    chk("busy_cfg_err_pulse", bus.cfg_err, 1);
    @(negedge sys_clk);
    chk("busy_cfg_err_clear", bus.cfg_err, 0);
    wait_out(4, n, got);
    chk("busy_cfg_latency", n, 9);
    chk("busy_cfg_data", got, 5);
    do_accept(100, 1'b0, 0, 0);
    wait_out(1, n, got);
    chk("busy_cfg_coef_kept", got, 100);

    // Reset in the middle of a computation restores coefficients too.
    cfg_write(0, 512);
    do_accept(300, 1'b0, 0, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.out_valid) cnt++;
      @(negedge sys_clk);
    end
    chk("midrst_no_out_valid", cnt, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_overrun", bus.overrun, 0);
    chk("midrst_cfg_err", bus.cfg_err, 0);
    model_reset();
    do_accept(55, 1'b0, 0, 0);
    wait_out(1, n, got);
    chk("midrst_next_sample", got, 55);

    // in_valid held high: one accept per NZ+NP+2 cycles, overrun sticks.
    do_reset();
    bus.in_valid = 1'b1;
    for (int c = 0; c < 36; c++) begin
      if (bus.in_ready) acc_cyc.push_back(c);
      if (c == 0) chk("cont_overrun_before", bus.overrun, 0);
      if (c == 2) chk("cont_overrun_set", bus.overrun, 1);
      bus.in_data = DW'($urandom);
      @(negedge sys_clk);
    end
    bus.in_valid = 1'b0;
    chk("cont_accept_count", acc_cyc.size(), 4);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk($sformatf("cont_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], NZ + NP + 2);
    chk("cont_overrun_sticky", bus.overrun, 1);
    repeat (12) @(negedge sys_clk);

    // Random coefficients and samples, occasional same-cycle writes.
    do_reset();
    for (int a = 0; a < NZ + NP; a++) begin
      rc = CW'($urandom);
      cfg_write(a, int'(rc));
    end
    for (int i = 0; i < 24; i++) begin
      bit we;
      int addr;
      int data;
      rd   = DW'($urandom);
      rc   = CW'($urandom);
      we   = ($urandom_range(0, 3) == 0);
      addr = $urandom_range(0, 7);
      data = int'(rc);
      do_accept(int'(rd), we, addr, data);
      if (we) model_cfg(addr, data);
      model_step(int'(rd), exp);
      wait_out(1, n, got);
      chk($sformatf("rand%0d_latency", i), n, 9);
      chk($sformatf("rand%0d_data", i), got, exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
